// File: rtl/tx_frame_sequencer.sv
// rtl/tx_frame_sequencer.sv - sequences one frame (marker, pixel words, line sync) onto four 6-bit transmit lanes
// Optional feature macro: TX_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module tx_frame_sequencer #(
   parameter int          SYM_CYC     = 25,
   parameter int          LINE_WORDS  = 160,
   parameter int          FRAME_WORDS = 76800,
   parameter logic [19:0] START_ADD   = 20'h0603e,
   parameter logic [23:0] FRAME1      = 24'haab155,
   parameter logic [23:0] FRAME0      = 24'haa8d55,
   parameter logic [7:0]  HSYNC       = 8'h55
) (
   input  logic        Cclk,
   input  logic        rstn,
   input  logic [19:0] cam_wadd,
   input  logic        frame_sync,
   input  logic [3:0]  mem_cont,
   output logic        rd_en,
   output logic [16:0] rd_add,
   input  logic        slot_ok,
   input  logic [47:0] rd_data,
   output logic        trans_valid,
   output logic [5:0]  trans0_data,
   output logic [5:0]  trans1_data,
   output logic [5:0]  trans2_data,
   output logic [5:0]  trans3_data,
   output logic        busy,
   output logic        frame_done,
   output logic [11:0] tran_line_count,
   output logic        underrun
`ifdef TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_cnt
`endif
);

   localparam int SCW = $clog2(SYM_CYC);
   localparam int CW  = $clog2(LINE_WORDS + 1);

   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DATA, S_HSYNC} state_t;

   state_t          state;
   logic [SCW-1:0]  sym_cnt;
   logic [4:0]      sym_idx;
   logic            half;
   logic [16:0]     word_idx;
   logic [CW-1:0]   col_idx;
   logic [23:0]     marker;
   logic [23:0]     lanes;
   logic [47:0]     word_reg;
   logic [1:0]      grant_pipe;
   logic [23:0]     first_mk;
   logic            start;
   logic            sym_end;
   logic            last_word;
   logic            line_end;
   logic            pre_word;
`ifdef TX_UNDERRUN_CNT_EN
   logic [15:0]     miss_cnt;
   assign underrun_cnt = miss_cnt;
`endif

   // All-ones or all-zeros symbol on every lane for marker and sync bits
   function automatic logic [23:0] bit_sym(input logic b);
      return b ? 24'hffffff : 24'h000000;
   endfunction

   // Upper or lower half of each lane's 12-bit word, disabled lanes forced to zero
   function automatic logic [23:0] word_sym(input logic [47:0] w, input logic hi, input logic [3:0] en);
      logic [23:0] s;
      s = '0;
      for (int k = 0; k < 4; k++)
         if (en[k]) s[6*k +: 6] = hi ? w[12*k+6 +: 6] : w[12*k +: 6];
      return s;
   endfunction

   assign busy        = (state != S_IDLE);
   assign start       = (state == S_IDLE) && (cam_wadd == START_ADD);
   assign first_mk    = frame_sync ? FRAME1 : FRAME0;
   assign sym_end     = (sym_cnt == SCW'(SYM_CYC - 1));
   assign last_word   = (word_idx == 17'(FRAME_WORDS - 1));
   assign line_end    = (col_idx == CW'(LINE_WORDS - 1));
   assign trans0_data = lanes[5:0];
   assign trans1_data = lanes[11:6];
   assign trans2_data = lanes[17:12];
   assign trans3_data = lanes[23:18];

   // Current symbol is the last one before a pixel word starts
   always_comb begin
      pre_word = 1'b0;
      case (state)
         S_FRAME: pre_word = (sym_idx == 5'd23);
         S_HSYNC: pre_word = (sym_idx == 5'd7);
         S_DATA:  pre_word = half && !last_word && !line_end;
         default: pre_word = 1'b0;
      endcase
   end

   // Symbol timing, state sequencing and registered lane outputs
   always_ff @(posedge Cclk or negedge rstn) begin
      if (!rstn) begin
         state           <= S_IDLE;
         sym_cnt         <= '0;
         sym_idx         <= '0;
         half            <= 1'b0;
         word_idx        <= '0;
         col_idx         <= '0;
         marker          <= '0;
         lanes           <= '0;
         trans_valid     <= 1'b0;
         frame_done      <= 1'b0;
         tran_line_count <= '0;
      end else begin
         frame_done <= 1'b0;
         if (state == S_IDLE) begin
            sym_cnt     <= '0;
            trans_valid <= 1'b0;
            lanes       <= '0;
            if (start) begin
               state           <= S_FRAME;
               lanes           <= bit_sym(first_mk[23]);
               marker          <= {first_mk[22:0], 1'b0};
               trans_valid     <= 1'b1;
               sym_idx         <= '0;
               half            <= 1'b0;
               word_idx        <= '0;
               col_idx         <= '0;
               tran_line_count <= '0;
            end
         end else begin
            trans_valid <= sym_end;
            sym_cnt     <= sym_end ? '0 : sym_cnt + 1'b1;
            if (sym_end) begin
               case (state)
                  S_FRAME: begin
                     if (sym_idx == 5'd23) begin
                        state <= S_DATA;
                        half  <= 1'b0;
                        lanes <= word_sym(word_reg, 1'b1, mem_cont);
                     end else begin
                        sym_idx <= sym_idx + 5'd1;
                        lanes   <= bit_sym(marker[23]);
                        marker  <= {marker[22:0], 1'b0};
                     end
                  end
                  S_HSYNC: begin
                     if (sym_idx == 5'd7) begin
                        state           <= S_DATA;
                        half            <= 1'b0;
                        tran_line_count <= tran_line_count + 12'd1;
                        lanes           <= word_sym(word_reg, 1'b1, mem_cont);
                     end else begin
                        sym_idx <= sym_idx + 5'd1;
                        lanes   <= bit_sym(marker[23]);
                        marker  <= {marker[22:0], 1'b0};
                     end
                  end
                  S_DATA: begin
                     if (!half) begin
                        half  <= 1'b1;
                        lanes <= word_sym(word_reg, 1'b0, mem_cont);
                     end else if (last_word) begin
                        state       <= S_IDLE;
                        frame_done  <= 1'b1;
                        trans_valid <= 1'b0;
                        lanes       <= '0;
                     end else begin
                        word_idx <= word_idx + 17'd1;
                        half     <= 1'b0;
                        if (line_end) begin
                           col_idx <= '0;
                           state   <= S_HSYNC;
                           sym_idx <= '0;
                           lanes   <= bit_sym(HSYNC[7]);
                           marker  <= {HSYNC[6:0], 17'h0};
                        end else begin
                           col_idx <= col_idx + 1'b1;
                           lanes   <= word_sym(word_reg, 1'b1, mem_cont);
                        end
                     end
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

   // Read-port request, grant tracking, data capture and late-grant substitution
   always_ff @(posedge Cclk or negedge rstn) begin
      if (!rstn) begin
         rd_en      <= 1'b0;
         rd_add     <= '0;
         grant_pipe <= '0;
         word_reg   <= '0;
         underrun   <= 1'b0;
`ifdef TX_UNDERRUN_CNT_EN
         miss_cnt   <= '0;
`endif
      end else begin
         grant_pipe <= {grant_pipe[0], rd_en & slot_ok};
         if (grant_pipe[1]) word_reg <= rd_data;
         if (start) begin
            underrun <= 1'b0;
`ifdef TX_UNDERRUN_CNT_EN
            miss_cnt <= '0;
`endif
         end else if (rd_en) begin
            if (slot_ok) begin
               rd_en <= 1'b0;
            end else if (sym_cnt == SCW'(SYM_CYC - 4)) begin
               // Deadline reached: drop the request and send a zero word
               rd_en    <= 1'b0;
               word_reg <= '0;
               underrun <= 1'b1;
`ifdef TX_UNDERRUN_CNT_EN
               if (miss_cnt != 16'hffff) miss_cnt <= miss_cnt + 16'd1;
`endif
            end
         end else if (busy && pre_word && sym_cnt == SCW'(SYM_CYC - 9)) begin
            rd_en  <= 1'b1;
            rd_add <= (state == S_DATA) ? word_idx + 17'd1 : word_idx;
         end
      end
   end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb/tb_tx_frame_sequencer.sv - scoreboard bench for tx_frame_sequencer (LINE_WORDS=4, FRAME_WORDS=8)
module tb_tx_frame_sequencer;

   localparam int          SYM   = 25;
   localparam int          LW    = 4;
   localparam int          NW    = 8;
   localparam logic [19:0] START = 20'h0603e;

   logic        Cclk = 1'b0;
   logic        rstn = 1'b0;
   logic [19:0] cam_wadd = 20'h0;
   logic        frame_sync = 1'b0;
   logic [3:0]  mem_cont = 4'h0;
   logic        rd_en;
   logic [16:0] rd_add;
   logic        slot_ok = 1'b0;
   logic [47:0] rd_data = 48'h0;
   logic        trans_valid;
   logic [5:0]  trans0_data, trans1_data, trans2_data, trans3_data;
   logic        busy;
   logic        frame_done;
   logic [11:0] tran_line_count;
   logic        underrun;
`ifdef TX_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif
   logic [23:0] lanes_w;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [23:0] exp_q[$];
   int          deny_addr = -1;
   int          exp_fetch = 0;
   int          cyc = 0;
   int          last_tv_cyc = 0;
   bit          have_tv = 1'b0;
   logic [23:0] last_lanes = 24'h0;
   bit          mon_prev = 1'b0;
   bit          resp_prev = 1'b0;
   int          req_age = 0;
   bit          d1_v = 1'b0, d2_v = 1'b0;
   int          d1_a = 0, d2_a = 0;
   int          delay_tab[8] = '{0, 3, 1, 4, 2, 0, 4, 1};

   assign lanes_w = {trans3_data, trans2_data, trans1_data, trans0_data};

   tx_frame_sequencer #(.LINE_WORDS(LW), .FRAME_WORDS(NW)) dut (
      .Cclk(Cclk), .rstn(rstn), .cam_wadd(cam_wadd), .frame_sync(frame_sync),
      .mem_cont(mem_cont), .rd_en(rd_en), .rd_add(rd_add), .slot_ok(slot_ok),
      .rd_data(rd_data), .trans_valid(trans_valid),
      .trans0_data(trans0_data), .trans1_data(trans1_data),
      .trans2_data(trans2_data), .trans3_data(trans3_data),
      .busy(busy), .frame_done(frame_done), .tran_line_count(tran_line_count),
      .underrun(underrun)
`ifdef TX_UNDERRUN_CNT_EN
      , .underrun_cnt(underrun_cnt)
`endif
   );

   always #5 Cclk = ~Cclk;

   always @(posedge Cclk) cyc <= cyc + 1;

   // Memory word contents per address; word 0 lane 0 is 12'habc
   function automatic logic [47:0] mem_word(input int a);
      logic [47:0] w;
      for (int k = 0; k < 4; k++) w[12*k +: 12] = 12'habc + 12'(a * 'h137) + 12'(k * 'h2d5);
      return w;
   endfunction

   // Shared read-port model: grants after a per-address delay, data two cycles after grant
   always @(negedge Cclk) begin
      rd_data = d2_v ? mem_word(d2_a) : 48'h5a5a_a5a5_c3c3;
      d2_v = d1_v;
      d2_a = d1_a;
      if (rd_en) req_age = resp_prev ? req_age + 1 : 0;
      resp_prev = rd_en;
      if (int'(rd_add) == deny_addr) slot_ok = !rd_en;
      else slot_ok = rd_en && (req_age >= delay_tab[rd_add[2:0]]);
      d1_v = rd_en && slot_ok;
      d1_a = int'(rd_add);
   end

   // Output monitor: pops expected symbols and checks symbol timing and fetch timing
   always @(negedge Cclk) begin
      logic [23:0] e;
      if (rstn) begin
         if (trans_valid) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL sym_extra: got %h want none", lanes_w);
            else begin
               e = exp_q.pop_front();
               if (lanes_w !== e) $display("FAIL sym: got %h want %h", lanes_w, e);
               else n_pass++;
            end
            if (have_tv) begin
               n_checks++;
               if (cyc - last_tv_cyc != SYM) $display("FAIL sym_spacing: got %0d want %0d", cyc - last_tv_cyc, SYM);
               else n_pass++;
            end
            have_tv = 1'b1;
            last_tv_cyc = cyc;
            last_lanes = lanes_w;
         end else if (busy && have_tv) begin
            n_checks++;
            if (lanes_w !== last_lanes) $display("FAIL lane_stable: got %h want %h", lanes_w, last_lanes);
            else n_pass++;
            if (cyc - last_tv_cyc == SYM - 3) begin
               n_checks++;
               if (rd_en !== 1'b0) $display("FAIL rd_en_deadline: got %b want 0", rd_en);
               else n_pass++;
            end
         end
         if (rd_en && !mon_prev) begin
            if (have_tv) begin
               n_checks++;
               if (cyc - last_tv_cyc != SYM - 8) $display("FAIL rd_en_rise: got %0d want %0d", cyc - last_tv_cyc, SYM - 8);
               else n_pass++;
            end
            n_checks++;
            if (int'(rd_add) != exp_fetch) $display("FAIL rd_add: got %0d want %0d", rd_add, exp_fetch);
            else n_pass++;
            exp_fetch++;
         end
         if (!busy) have_tv = 1'b0;
      end
      mon_prev = rd_en;
   end

   // Expected lane symbols for a whole frame
   task automatic push_frame(input logic fs, input logic [3:0] mc, input int deny);
      logic [23:0] mk;
      logic [7:0]  hs;
      logic [47:0] w;
      logic [23:0] s_hi, s_lo;
      mk = fs ? 24'haab155 : 24'haa8d55;
      hs = 8'h55;
      for (int i = 23; i >= 0; i--) exp_q.push_back(mk[i] ? 24'hffffff : 24'h0);
      for (int a = 0; a < NW; a++) begin
         w = (a == deny) ? 48'h0 : mem_word(a);
         for (int k = 0; k < 4; k++) begin
            s_hi[6*k +: 6] = mc[k] ? w[12*k+6 +: 6] : 6'h00;
            s_lo[6*k +: 6] = mc[k] ? w[12*k +: 6] : 6'h00;
         end
         exp_q.push_back(s_hi);
         exp_q.push_back(s_lo);
         if ((a + 1) % LW == 0 && a + 1 != NW)
            for (int j = 7; j >= 0; j--) exp_q.push_back(hs[j] ? 24'hffffff : 24'h0);
      end
   endtask

   task automatic run_frame(input logic fs, input logic [3:0] mc, input int deny, input bit poke);
      bit seen;
      frame_sync = fs;
      mem_cont   = mc;
      deny_addr  = deny;
      push_frame(fs, mc, deny);
      exp_fetch  = 0;
      @(negedge Cclk);
      cam_wadd = START;
      @(negedge Cclk);
      cam_wadd = 20'h0;
      frame_sync = ~fs;
      n_checks++;
      if (trans_valid !== 1'b1 || busy !== 1'b1) $display("FAIL start_latency: got tv=%b busy=%b want 1 1", trans_valid, busy);
      else n_pass++;
      n_checks++;
      if (underrun !== 1'b0 || tran_line_count !== 12'd0) $display("FAIL start_clear: got underrun=%b lines=%0d want 0 0", underrun, tran_line_count);
      else n_pass++;
      seen = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge Cclk);
         cam_wadd = (poke && n >= 300 && n < 303) ? START : 20'h0;
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) $display("FAIL frame_done_timeout: got none want pulse");
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy);
      else n_pass++;
      @(negedge Cclk);
      n_checks++;
      if (frame_done !== 1'b0) $display("FAIL done_width: got %b want 0", frame_done);
      else n_pass++;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL sb_empty: got %0d left want 0", exp_q.size());
      else n_pass++;
      n_checks++;
      if (tran_line_count !== 12'(NW / LW - 1)) $display("FAIL line_count: got %0d want %0d", tran_line_count, NW / LW - 1);
      else n_pass++;
      n_checks++;
      if (lanes_w !== 24'h0 || trans_valid !== 1'b0) $display("FAIL idle_lanes: got %h tv=%b want 0 0", lanes_w, trans_valid);
      else n_pass++;
      deny_addr = -1;
   endtask

   task automatic test_reset;
      int tv_seen;
      rstn = 1'b0;
      repeat (3) @(negedge Cclk);
      n_checks++;
      if (trans_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || underrun !== 1'b0)
         $display("FAIL reset_flags: got tv=%b rd_en=%b busy=%b done=%b ur=%b want 0", trans_valid, rd_en, busy, frame_done, underrun);
      else n_pass++;
      n_checks++;
      if (rd_add !== 17'h0 || tran_line_count !== 12'h0 || lanes_w !== 24'h0)
         $display("FAIL reset_values: got add=%h lines=%h lanes=%h want 0", rd_add, tran_line_count, lanes_w);
      else n_pass++;
`ifdef TX_UNDERRUN_CNT_EN
      n_checks++;
      if (underrun_cnt !== 16'h0) $display("FAIL reset_ucnt: got %h want 0", underrun_cnt);
      else n_pass++;
`endif
      rstn = 1'b1;
      cam_wadd = 20'h0603d;
      tv_seen = 0;
      repeat (50) begin
         @(negedge Cclk);
         if (trans_valid || busy) tv_seen++;
      end
      cam_wadd = 20'h0;
      n_checks++;
      if (tv_seen != 0) $display("FAIL idle_no_start: got %0d active cycles want 0", tv_seen);
      else n_pass++;
   endtask

   task automatic test_marker_data;
      run_frame(1'b1, 4'b0001, -1, 1'b0);
      n_checks++;
      if (underrun !== 1'b0) $display("FAIL no_underrun: got %b want 0", underrun);
      else n_pass++;
   endtask

   task automatic test_underrun;
      run_frame(1'b0, 4'b1011, 2, 1'b1);
      n_checks++;
      if (underrun !== 1'b1) $display("FAIL underrun_flag: got %b want 1", underrun);
      else n_pass++;
`ifdef TX_UNDERRUN_CNT_EN
      n_checks++;
      if (underrun_cnt !== 16'd1) $display("FAIL underrun_cnt: got %0d want 1", underrun_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back;
      run_frame(1'b1, 4'b1111, -1, 1'b0);
      n_checks++;
      if (underrun !== 1'b0) $display("FAIL restart_underrun: got %b want 0", underrun);
      else n_pass++;
   endtask

   task automatic test_abort;
      int dones;
      frame_sync = 1'b1;
      mem_cont   = 4'hf;
      deny_addr  = -1;
      push_frame(1'b1, 4'hf, -1);
      exp_fetch  = 0;
      @(negedge Cclk);
      cam_wadd = START;
      @(negedge Cclk);
      cam_wadd = 20'h0;
      repeat (700) @(negedge Cclk);
      @(posedge Cclk);
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || trans_valid !== 1'b0 || rd_en !== 1'b0 || lanes_w !== 24'h0 || tran_line_count !== 12'h0)
         $display("FAIL abort_reset: got busy=%b tv=%b rd_en=%b lanes=%h lines=%0d want 0", busy, trans_valid, rd_en, lanes_w, tran_line_count);
      else n_pass++;
      exp_q.delete();
      repeat (3) @(negedge Cclk);
      rstn = 1'b1;
      dones = 0;
      repeat (60) begin
         @(negedge Cclk);
         if (frame_done || busy) dones++;
      end
      n_checks++;
      if (dones != 0) $display("FAIL abort_no_done: got %0d want 0", dones);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_marker_data();
      test_underrun();
      test_back_to_back();
      test_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tx_frame_sequencer.md
# tx_frame_sequencer

Sequences one video frame out of the four slanted Y memories onto the four 6-bit transmit lanes. It emits a 24-symbol frame marker, then pixel words of two symbols each, with an 8-symbol line-sync burst between lines. It requests the shared memory read port once per word and tolerates a late grant by substituting zero data. It sits beside the camera write path and the HDMI reader, and acts as the transmit requester on the shared read port.

## Interface
- SYM_CYC, 25: Cclk cycles per transmitted symbol (minimum 10).
- LINE_WORDS, 160: words per line.
- FRAME_WORDS, 76800: words per frame.
- START_ADD, 20'h0603e: camera write address that triggers a frame.
- FRAME1, 24'haab155: frame marker sent when frame_sync=1.
- FRAME0, 24'haa8d55: frame marker sent when frame_sync=0.
- HSYNC, 8'h55: line-sync pattern.
- Cclk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- cam_wadd  in  20  current camera write address.
- frame_sync  in  1  frame parity; sampled at start.
- mem_cont  in  4  lane enables.
- rd_en  out  1  read-port request.
- rd_add  out  17  word address (= word index).
- slot_ok  in  1  read-port grant, valid when rd_en=1.
- rd_data  in  48  lane k word at [12k+11:12k]; valid 2 cycles after the grant cycle.
- trans_valid  out  1  one-cycle symbol strobe.
- trans0_data … trans3_data  out  6 each  lane symbols.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- tran_line_count  out  12  lines completed in the current frame.
- underrun  out  1  sticky: a word was not fetched in time.

## Operation
- States:
  - IDLE: start when cam_wadd==START_ADD. Latch FRAME1 or FRAME0 from frame_sync, clear word_idx, tran_line_count and underrun, then go to FRAME.
  - FRAME: 24 symbols, MSB first. Bit 1 sends 6'h3f and bit 0 sends 6'h00 on all lanes. Then go to DATA.
  - DATA: each word is sent as two symbols, rd_data[11:6] then [5:0] of that lane. A lane with mem_cont[k]=0 sends 6'h00.
  - After the second symbol of a word, word_idx increments:
    - If word_idx+1==FRAME_WORDS: pulse frame_done and go to IDLE.
    - Else if (word_idx+1) % LINE_WORDS==0: go to HSYNC.
  - HSYNC: 8 symbols of the HSYNC pattern, sent like the marker on all lanes regardless of mem_cont. On exit, tran_line_count increments and the state returns to DATA.
- cam_wadd==START_ADD while busy is ignored.
- Fetch handshake:
  - rd_en rises at sym_cnt==SYM_CYC-8 of the last symbol before each word. That symbol is the final FRAME or HSYNC symbol, or the low-half symbol of the previous word.
  - rd_en holds until the first cycle with slot_ok=1, then drops the next cycle.
  - Data is captured 2 cycles after the grant cycle.
  - If no grant arrives by sym_cnt==SYM_CYC-3, rd_en drops, the word is taken as 48'h0 and underrun is set.
- busy = (state != IDLE).

## Timing
- sym_cnt counts 0..SYM_CYC-1 in every non-IDLE state and is held at 0 in IDLE.
- trans_valid = (state != IDLE) && sym_cnt==0.
- Lane outputs are registered and change only in the cycle where sym_cnt becomes 0, so they are stable for the whole symbol.
- The start condition seen in cycle N gives the first trans_valid in cycle N+1.
- In IDLE all lanes output 6'h00.
- Reset values: all lane outputs 6'h00; trans_valid, rd_en, busy, frame_done and underrun 0; rd_add 0; tran_line_count 0; state IDLE.
- Asserting rstn mid-frame aborts immediately. No frame_done is produced.
- A grant arriving in the same cycle rd_en is dropped for the deadline is ignored.

## Configuration
- TX_UNDERRUN_CNT_EN:
  - Defined: adds output underrun_cnt [15:0]. It increments on every substituted word, saturates at 16'hffff, and clears at frame start.
  - Undefined: the port is absent and only the sticky underrun flag exists.

## Test plan
- Reset: hold rstn low, then release. All outputs at their reset values; no trans_valid while cam_wadd != START_ADD.
- Frame marker: cam_wadd=20'h0603e with frame_sync=1. The first 24 lane symbols follow aab155: 3f,00,3f,00,3f,00,3f,00,3f,00,3f,3f,… with trans_valid every 25 cycles.
- Data split: grant immediately, lane0 word 12'habc, mem_cont=4'b0001. Lane0 sends 6'h2a then 6'h3c; lanes 1-3 send 6'h00.
- Line sync: LINE_WORDS=4, FRAME_WORDS=8. After word 3, 8 symbols 00,3f,00,3f,00,3f,00,3f on all lanes, then tran_line_count=1.
- Underrun: hold slot_ok=0 for word 2. Both symbols of that word are 6'h00 and underrun=1 (underrun_cnt=1 when TX_UNDERRUN_CNT_EN is defined). The next word fetches normally.
- End of frame: FRAME_WORDS=8. After 16 data symbols, frame_done pulses for 1 cycle and busy drops. A new start then restarts with the marker and clears underrun.
